// File: rtl/verdict_ser_pkg.sv
// verdict_ser_pkg: shared types, default sizes and helpers for the verdict stream serializer.
package verdict_ser_pkg;
  localparam int DEF_NUM_OUTPUTS = 8;
  localparam int DEF_DATA_W = 64;
  localparam int DEF_TS_W = 32;
  localparam int DEF_FIFO_DEPTH = 8;
  localparam int IDX_W = $clog2(DEF_NUM_OUTPUTS);
  typedef enum logic {IDLE, EMIT} state_e;
  typedef struct packed {
    logic [DEF_TS_W-1:0] ts;
    logic [DEF_NUM_OUTPUTS-1:0] mask;
    logic [DEF_NUM_OUTPUTS-1:0][DEF_DATA_W-1:0] data;
  } verdict_rec_t;
  function automatic logic [IDX_W-1:0] lowest_set(input logic [DEF_NUM_OUTPUTS-1:0] m);
    lowest_set = '0;
    for (int i = DEF_NUM_OUTPUTS - 1; i >= 0; i--)
      if (m[i]) lowest_set = IDX_W'(i);
  endfunction
endpackage

// File: rtl/verdict_ser_fifo.sv
// verdict_fifo: count-based synchronous FIFO of verdict records with a combinational head.
module verdict_fifo
  import verdict_ser_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  verdict_rec_t din,
  output verdict_rec_t dout,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  verdict_rec_t mem [DEPTH];
  logic [AW-1:0] wr, rd;
  logic do_push, do_pop;
  assign full = level == (AW+1)'(DEPTH);
  assign empty = level == '0;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = mem[rd];
  always_ff @(posedge clk)
    if (do_push) mem[wr] <= din;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr <= '0;
      rd <= '0;
      level <= '0;
    end else begin
      if (do_push) wr <= wr + 1'b1;
      if (do_pop) rd <= rd + 1'b1;
      level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/verdict_stream_serializer.sv
// verdict_stream_serializer: queues cycles with active monitor outputs and emits one beat per active output.
// Define VERDICT_DROP_CNT_EN to add the saturating drop_count port.
module verdict_stream_serializer
  import verdict_ser_pkg::*;
#(
  parameter int NUM_OUTPUTS = DEF_NUM_OUTPUTS,
  parameter int DATA_W = DEF_DATA_W,
  parameter int TS_W = DEF_TS_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic [NUM_OUTPUTS*DATA_W-1:0] out_data,
  input  logic [NUM_OUTPUTS-1:0] out_aktv,
  output logic m_valid,
  input  logic m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [$clog2(NUM_OUTPUTS)-1:0] m_idx,
  output logic [TS_W-1:0] m_ts,
  output logic m_last,
  output logic overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
`ifdef VERDICT_DROP_CNT_EN
  , output logic [15:0] drop_count
`endif
);
  // Record layout comes from the package constants; the parameters must keep their defaults.
  verdict_rec_t rec_in, head, hold;
  state_e state, state_nx;
  logic [TS_W-1:0] ts;
  logic full, empty, push, pop, accept, drop;
  assign rec_in = '{ts: ts, mask: out_aktv, data: out_data};
  assign push = en && |out_aktv;
  assign m_valid = state == EMIT;
  assign accept = en && m_valid && m_ready;
  assign m_idx = lowest_set(hold.mask);
  assign m_data = m_valid ? hold.data[m_idx] : '0;
  assign m_ts = m_valid ? hold.ts : '0;
  assign m_last = m_valid && $onehot(hold.mask);
  assign pop = en && !empty && (state == IDLE || (accept && m_last));
  assign drop = push && full && !pop;
  verdict_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .din(rec_in), .dout(head),
    .full(full), .empty(empty), .level(fifo_level)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (state == IDLE && pop) state_nx = EMIT;
    else if (state == EMIT && accept && m_last && !pop) state_nx = IDLE;
  end
  // Each accepted beat retires its mask bit; a pop replaces the whole record.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ts <= '0;
      hold <= '0;
      overflow <= 1'b0;
    end else begin
      if (en) ts <= ts + 1'b1;
      if (pop) hold <= head;
      else if (accept) hold.mask <= hold.mask & ~(NUM_OUTPUTS'(1) << m_idx);
      if (drop) overflow <= 1'b1;
    end
`ifdef VERDICT_DROP_CNT_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) drop_count <= '0;
    else if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 1'b1;
`endif
endmodule

// File: tb/tb_verdict_stream_serializer.sv
// tb_verdict_stream_serializer: directed scenarios plus randomized traffic against a queue-based model.
module tb_verdict_stream_serializer;
  typedef struct packed {
    logic [31:0] ts;
    logic [7:0] mask;
    logic [7:0][63:0] data;
  } rec_t;

  logic clk = 1'b0, rst, en, m_ready, m_valid, m_last, overflow;
  logic [511:0] out_data;
  logic [7:0] out_aktv;
  logic [63:0] m_data;
  logic [2:0] m_idx;
  logic [31:0] m_ts;
  logic [3:0] fifo_level;
`ifdef VERDICT_DROP_CNT_EN
  logic [15:0] drop_count;
`endif

  verdict_stream_serializer dut (
    .clk(clk), .rst(rst), .en(en), .out_data(out_data), .out_aktv(out_aktv),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_idx(m_idx), .m_ts(m_ts),
    .m_last(m_last), .overflow(overflow), .fifo_level(fifo_level)
`ifdef VERDICT_DROP_CNT_EN
    , .drop_count(drop_count)
`endif
  );

  always #5 clk = ~clk;

  int passed = 0, total = 0;
  rec_t q[$];
  rec_t cur;
  bit busy, ovf;
  int drops;
  logic [31:0] mts;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic int low(input logic [7:0] m);
    for (int i = 0; i < 8; i++) if (m[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    q.delete();
    cur = '0;
    busy = 0;
    ovf = 0;
    drops = 0;
    mts = '0;
  endtask

  // One clock edge of the reference behaviour, using the inputs held across that edge.
  task automatic model_step();
    bit acc, done, take, full0;
    rec_t r;
    if (!en) return;
    full0 = q.size() == 8;
    acc = busy && m_ready;
    done = acc && $countones(cur.mask) == 1;
    if (acc) cur.mask[low(cur.mask)] = 1'b0;
    take = (!busy || done) && q.size() > 0;
    if (take) begin
      cur = q.pop_front();
      busy = 1;
    end else if (done) busy = 0;
    if (|out_aktv) begin
      if (full0 && !take) begin
        ovf = 1;
        drops++;
      end else begin
        r.ts = mts;
        r.mask = out_aktv;
        r.data = out_data;
        q.push_back(r);
      end
    end
    mts = mts + 1;
  endtask

  task automatic compare();
    int k;
    check("valid", 64'(m_valid), 64'(busy));
    check("level", 64'(fifo_level), 64'(q.size()));
    check("overflow", 64'(overflow), 64'(ovf));
`ifdef VERDICT_DROP_CNT_EN
    check("drop_count", 64'(drop_count), 64'(drops > 65535 ? 65535 : drops));
`endif
    if (busy) begin
      k = low(cur.mask);
      check("idx", 64'(m_idx), 64'(k));
      check("data", m_data, cur.data[k]);
      check("ts", 64'(m_ts), 64'(cur.ts));
      check("last", 64'(m_last), 64'($countones(cur.mask) == 1));
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst) model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic do_reset();
    rst = 1;
    #1;
    model_reset();
    check("rst_valid", 64'(m_valid), 64'd0);
    check("rst_level", 64'(fifo_level), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  task automatic rand_data();
    for (int i = 0; i < 16; i++) out_data[i*32 +: 32] = $urandom;
  endtask

  initial begin
    rst = 1; en = 1; m_ready = 1; out_aktv = '0; out_data = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("init_valid", 64'(m_valid), 64'd0);
    check("init_data", m_data, 64'd0);
    check("init_level", 64'(fifo_level), 64'd0);
    check("init_ovf", 64'(overflow), 64'd0);
    rst = 0;
    // two-beat record, first beat after the second edge
    out_aktv = 8'h05; out_data[63:0] = 64'd1; out_data[191:128] = 64'd3;
    step();
    out_aktv = '0;
    check("t1_latency", 64'(m_valid), 64'd0);
    step();
    check("t1_b0_valid", 64'(m_valid), 64'd1);
    check("t1_b0_idx", 64'(m_idx), 64'd0);
    check("t1_b0_data", m_data, 64'd1);
    check("t1_b0_last", 64'(m_last), 64'd0);
    check("t1_b0_ts", 64'(m_ts), 64'd0);
    step();
    check("t1_b1_idx", 64'(m_idx), 64'd2);
    check("t1_b1_data", m_data, 64'd3);
    check("t1_b1_last", 64'(m_last), 64'd1);
    check("t1_b1_ts", 64'(m_ts), 64'd0);
    step();
    check("t1_done", 64'(m_valid), 64'd0);
    // stall holds the beat
    m_ready = 0; out_aktv = 8'h82; out_data = '0;
    out_data[127:64] = 64'hAA; out_data[511:448] = 64'hBB;
    step();
    out_aktv = '0;
    step();
    for (int i = 0; i < 5; i++) begin
      check("t2_stall_valid", 64'(m_valid), 64'd1);
      check("t2_stall_idx", 64'(m_idx), 64'd1);
      check("t2_stall_data", m_data, 64'hAA);
      check("t2_stall_last", 64'(m_last), 64'd0);
      step();
    end
    m_ready = 1;
    step();
    check("t2_b1_idx", 64'(m_idx), 64'd7);
    check("t2_b1_data", m_data, 64'hBB);
    check("t2_b1_last", 64'(m_last), 64'd1);
    step();
    check("t2_done", 64'(m_valid), 64'd0);
    // blocker in hold, then nine single-bit records: ninth is dropped
    m_ready = 0; out_aktv = 8'h01; rand_data();
    step();
    out_aktv = '0;
    step();
    for (int i = 0; i < 9; i++) begin
      out_aktv = 8'(1 << (i % 8)); rand_data();
      step();
    end
    out_aktv = '0;
    check("t3_level", 64'(fifo_level), 64'd8);
    check("t3_ovf", 64'(overflow), 64'd1);
`ifdef VERDICT_DROP_CNT_EN
    check("t3_drop_count", 64'(drop_count), 64'd1);
`endif
    do_reset();
    // full FIFO with a same-edge pop accepts the capture
    m_ready = 0; out_aktv = 8'h01; rand_data();
    step();
    out_aktv = '0;
    step();
    for (int i = 0; i < 8; i++) begin
      out_aktv = 8'(1 << i); rand_data();
      step();
    end
    check("t4_full", 64'(fifo_level), 64'd8);
    m_ready = 1; out_aktv = 8'h10; rand_data();
    step();
    out_aktv = '0;
    check("t4_level", 64'(fifo_level), 64'd8);
    check("t4_ovf", 64'(overflow), 64'd0);
    repeat (12) step();
    check("t4_drained", 64'(fifo_level), 64'd0);
    check("t4_idle", 64'(m_valid), 64'd0);
    // back-to-back full records, no bubble
    out_aktv = 8'hFF; rand_data();
    step();
    rand_data();
    step();
    out_aktv = '0;
    for (int b = 1; b <= 16; b++) begin
      check("t5_valid", 64'(m_valid), 64'd1);
      check("t5_last", 64'(m_last), 64'(b == 8 || b == 16));
      step();
    end
    check("t5_done", 64'(m_valid), 64'd0);
    // reset at beat 3 of 8
    out_aktv = 8'hFF; rand_data();
    step();
    out_aktv = '0;
    repeat (3) step();
    check("t6_beat3", 64'(m_idx), 64'd2);
    do_reset();
    out_aktv = 8'h01; out_data[63:0] = 64'h77;
    step();
    out_aktv = '0;
    step();
    check("t6_ts_restart", 64'(m_ts), 64'd0);
    check("t6_data", m_data, 64'h77);
    step();
    // randomized traffic with varying sink pressure
    for (int p = 0; p < 4; p++) begin
      repeat (600) begin
        en = ($urandom % 8) != 0;
        out_aktv = ($urandom % 3 == 0) ? 8'($urandom) : 8'h00;
        rand_data();
        m_ready = (p == 1) ? ($urandom % 6 == 0) : ($urandom % 4 != 0);
        step();
      end
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
